hazard_stall_unit: RTL and testbench

- Stall and flush controller for the 5-stage pipeline. It handles the hazards that the operand-forwarding path cannot resolve: load-use hazards, and branch/jr operands that are not yet available at the ID-stage comparator.
- It holds PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on taken control transfers.
- Multi-cycle stalls are tracked by an internal state machine and are not re-evaluated mid-stall. A global freeze input suspends all progress.

---
 rtl/hazard_stall_unit_if.sv | 35 +++
 rtl/hazard_stall_unit.sv | 99 +++++++++
 tb/tb_hazard_stall_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard stall/flush controller.
// The master modport is the datapath side; the slave modport is the controller.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFID_rs;
  logic [4:0]       IFID_rt;
  logic             IFID_usert;
  logic [2:0]       IFID_pcsrc;
  logic             IFID_taken;
  logic [4:0]       IDEX_rd;
  logic             IDEX_regwr;
  logic             IDEX_memrd;
  logic [4:0]       EXMEM_rd;
  logic             EXMEM_memrd;
  logic             mem_busy;
  logic             PC_wr_en;
  logic             IFID_wr_en;
  logic             IDEX_bubble;
  logic             IFID_flush;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output IFID_rs, IFID_rt, IFID_usert, IFID_pcsrc, IFID_taken,
    output IDEX_rd, IDEX_regwr, IDEX_memrd, EXMEM_rd, EXMEM_memrd, mem_busy,
    input  PC_wr_en, IFID_wr_en, IDEX_bubble, IFID_flush, pipe_freeze, stall_cycles
  );

  modport slave (
    input  IFID_rs, IFID_rt, IFID_usert, IFID_pcsrc, IFID_taken,
    input  IDEX_rd, IDEX_regwr, IDEX_memrd, EXMEM_rd, EXMEM_memrd, mem_busy,
    output PC_wr_en, IFID_wr_en, IDEX_bubble, IFID_flush, pipe_freeze, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and branch-operand
// stalls, taken-transfer flushes, memory freeze and a saturating bubble counter.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             r_q, r_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       hit_e, hit_m, cmp;
  logic [1:0] n;
  logic       pc_wr_en, ifid_wr_en, idex_bubble, ifid_flush;

  always_comb begin
    hit_e = (hz.IDEX_rd != 5'd0) &&
            ((hz.IDEX_rd == hz.IFID_rs) || (hz.IFID_usert && (hz.IDEX_rd == hz.IFID_rt)));
    hit_m = (hz.EXMEM_rd != 5'd0) &&
            ((hz.EXMEM_rd == hz.IFID_rs) || (hz.IFID_usert && (hz.EXMEM_rd == hz.IFID_rt)));
    cmp   = (hz.IFID_pcsrc == 3'd1) || (hz.IFID_pcsrc == 3'd3);

    n = 2'd0;
    if (cmp && hz.IDEX_memrd && hit_e)        n = 2'd2;
    else if (cmp && hz.IDEX_regwr && hit_e)   n = 2'd1;
    else if (cmp && hz.EXMEM_memrd && hit_m)  n = 2'd1;
    else if (!cmp && hz.IDEX_memrd && hit_e)  n = 2'd1;
  end

  // A stall always wins over a flush: branch operands are stale while stalled.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    pc_wr_en    = 1'b1;
    ifid_wr_en  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;

    if (hz.mem_busy) begin
      pc_wr_en   = 1'b0;
      ifid_wr_en = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (n != 2'd0) begin
            pc_wr_en    = 1'b0;
            ifid_wr_en  = 1'b0;
            idex_bubble = 1'b1;
            if (n == 2'd2) begin
              state_d = STALL;
              r_d     = 1'b1;
            end
          end else begin
            ifid_flush = hz.IFID_taken;
          end
        end
        STALL: begin
          pc_wr_en    = 1'b0;
          ifid_wr_en  = 1'b0;
          idex_bubble = 1'b1;
          r_d         = r_q - 1'b1;
          if (r_d == 1'b0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    stall_cycles_d = stall_cycles_q;
    if (idex_bubble && (stall_cycles_q != CNT_MAX))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      r_q            <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      r_q            <= r_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.PC_wr_en     = pc_wr_en;
  assign hz.IFID_wr_en   = ifid_wr_en;
  assign hz.IDEX_bubble  = idex_bubble;
  assign hz.IFID_flush   = ifid_flush;
  assign hz.pipe_freeze  = hz.mem_busy;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_stall_unit;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct {
    logic [4:0]       outs;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) hz_if ();

  hazard_stall_unit #(.CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if.slave)
  );

  always #5 clk = ~clk;

  exp_t             exp_q[$];
  exp_t             cur;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  // Outputs packed as {PC_wr_en, IFID_wr_en, IDEX_bubble, IFID_flush, pipe_freeze}.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      if ({hz_if.PC_wr_en, hz_if.IFID_wr_en, hz_if.IDEX_bubble,
           hz_if.IFID_flush, hz_if.pipe_freeze} !== cur.outs) begin
        n_fail++;
        $display("[TB] FAIL %s outputs pc/ifid/bub/flush/frz: got %b expected %b", cur.tag,
                 {hz_if.PC_wr_en, hz_if.IFID_wr_en, hz_if.IDEX_bubble,
                  hz_if.IFID_flush, hz_if.pipe_freeze}, cur.outs);
      end
      n_checks++;
      if (hz_if.stall_cycles !== cur.cnt) begin
        n_fail++;
        $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", cur.tag,
                 hz_if.stall_cycles, cur.cnt);
      end
    end
  end

  // exp_bits = {PC_wr_en, IFID_wr_en, IDEX_bubble, IFID_flush}; freeze is expected to follow busy.
  task automatic apply_stimulus(
    input string      tag,
    input logic       rst,
    input logic       busy,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       usert,
    input logic [2:0] pcsrc,
    input logic       taken,
    input logic [4:0] ex_rd,
    input logic       ex_wr,
    input logic       ex_ld,
    input logic [4:0] mem_rd,
    input logic       mem_ld,
    input logic [3:0] exp_bits
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    hz_if.mem_busy    = busy;
    hz_if.IFID_rs     = rs;
    hz_if.IFID_rt     = rt;
    hz_if.IFID_usert  = usert;
    hz_if.IFID_pcsrc  = pcsrc;
    hz_if.IFID_taken  = taken;
    hz_if.IDEX_rd     = ex_rd;
    hz_if.IDEX_regwr  = ex_wr;
    hz_if.IDEX_memrd  = ex_ld;
    hz_if.EXMEM_rd    = mem_rd;
    hz_if.EXMEM_memrd = mem_ld;
    if (rst) exp_cnt = '0;
    e.outs = {exp_bits, busy};
    e.cnt  = exp_cnt;
    e.tag  = tag;
    exp_q.push_back(e);
    if (!rst && !busy && exp_bits[1] && (exp_cnt != CNT_MAX)) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic idle(input string tag);
    apply_stimulus(tag, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0,
                   5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100);
  endtask

  initial begin
    hz_if.mem_busy    = 1'b0;
    hz_if.IFID_rs     = '0;
    hz_if.IFID_rt     = '0;
    hz_if.IFID_usert  = 1'b0;
    hz_if.IFID_pcsrc  = '0;
    hz_if.IFID_taken  = 1'b0;
    hz_if.IDEX_rd     = '0;
    hz_if.IDEX_regwr  = 1'b0;
    hz_if.IDEX_memrd  = 1'b0;
    hz_if.EXMEM_rd    = '0;
    hz_if.EXMEM_memrd = 1'b0;

    apply_stimulus("reset", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100);
    idle("post_reset");

    apply_stimulus("ld_use_alu", 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 3'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);
    apply_stimulus("ld_use_after", 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 4'b1100);

    // The STALL cycle drives taken=1 and a MEM-stage hazard; both must be ignored.
    apply_stimulus("ld_beq_1", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);
    apply_stimulus("ld_beq_2", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b0010);
    apply_stimulus("ld_beq_done", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100);

    apply_stimulus("alu_jr", 1'b0, 1'b0, 5'd31, 5'd0, 1'b0, 3'd3, 1'b0, 5'd31, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0010);
    apply_stimulus("alu_jr_after", 1'b0, 1'b0, 5'd31, 5'd0, 1'b0, 3'd3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b0, 4'b1100);

    apply_stimulus("zero_reg", 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 3'd1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 4'b1100);

    apply_stimulus("taken_flush", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 3'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1101);
    idle("taken_after");
    apply_stimulus("taken_hazard", 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 3'd0, 1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);

    apply_stimulus("beq_mem_load", 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 4'b0010);
    apply_stimulus("alu_mem_load", 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 4'b1100);
    apply_stimulus("alu_fwd_ex", 1'b0, 1'b0, 5'd7, 5'd0, 1'b0, 3'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 4'b1100);
    apply_stimulus("rt_unused", 1'b0, 1'b0, 5'd1, 5'd6, 1'b0, 3'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 4'b1100);
    apply_stimulus("rt_used", 1'b0, 1'b0, 5'd1, 5'd6, 1'b1, 3'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);

    apply_stimulus("frz_ld_beq_1", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);
    apply_stimulus("frz_stall_a", 1'b0, 1'b1, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b0000);
    apply_stimulus("frz_stall_b", 1'b0, 1'b1, 5'd0, 5'd9, 1'b1, 3'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b0000);
    apply_stimulus("frz_resume", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'b0010);
    apply_stimulus("frz_done", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100);

    apply_stimulus("frz_taken", 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 3'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000);
    apply_stimulus("deferred_flush", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 3'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1101);
    apply_stimulus("frz_hazard", 1'b0, 1'b1, 5'd8, 5'd0, 1'b0, 3'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0000);
    apply_stimulus("deferred_stall", 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 3'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);

    apply_stimulus("rst_ld_beq_1", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 3'd1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);
    apply_stimulus("rst_mid_stall", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b1100);
    idle("rst_release");

    for (int i = 0; i < 18; i++)
      apply_stimulus("saturate", 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 3'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 4'b0010);
    idle("sat_hold");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
